// File: rtl/score_seg_driver.sv
// Binary score -> BCD (sequential double-dabble) -> 4-digit multiplexed 7-segment scan driver.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits above digit 0).
module score_seg_driver #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned SCAN_HZ = 1_000,
  parameter int unsigned NUM_W   = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_W-1:0] number,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp,
  output logic             busy
);

  localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW  = $clog2(NUM_W + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

  state_e           r_state, w_state_d;
  logic [NUM_W-1:0] r_bin, r_last;
  logic [27:0]      r_bcd, w_bcd_adj;
  logic [CW-1:0]    r_cnt;
  logic             r_pending;
  logic [15:0]      r_disp;
  logic             r_ovf;
  logic [PW-1:0]    r_presc;
  logic [1:0]       r_idx;
  logic [3:0]       w_digit;
  logic             w_blank;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'h7F;
    endcase
  endfunction

  // Double-dabble correction: any nibble >= 5 would overflow past 9 after the shift.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int k = 0; k < 7; k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (r_pending || (number != r_last)) w_state_d = StLoad;
      StLoad:  w_state_d = StShift;
      StShift: if (r_cnt == CW'(NUM_W - 1)) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  assign busy = (r_state != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_bin     <= '0;
      r_last    <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_pending <= 1'b1;
      r_disp    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        StLoad: begin
          r_bin     <= number;
          r_last    <= number;
          r_bcd     <= '0;
          r_cnt     <= '0;
          r_pending <= 1'b0;
        end
        StShift: begin
          {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
          r_cnt          <= r_cnt + 1'b1;
        end
        StDone: begin
          if (|r_bcd[27:16]) begin
            r_disp <= 16'h9999;
            r_ovf  <= 1'b1;
          end else begin
            r_disp <= r_bcd[15:0];
            r_ovf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_digit = r_disp[4*r_idx +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    w_blank = 1'b0;
    case (r_idx)
      2'd3:    w_blank = (r_disp[15:12] == 4'd0);
      2'd2:    w_blank = (r_disp[15:8] == 8'd0);
      2'd1:    w_blank = (r_disp[15:4] == 12'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
      an      <= 4'hF;
      seg     <= 7'h7F;
      dp      <= 1'b1;
    end else begin
      if (r_presc == PW'(DIV - 1)) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
      an  <= ~(4'b0001 << r_idx);
      seg <= w_blank ? 7'h7F : decode(w_digit);
      dp  <= ~(r_ovf && (r_idx == 2'd0));
    end
  end

endmodule

// File: tb/tb_score_seg_driver.sv
// Bench for score_seg_driver: random and directed scores checked against a decimal reference model.
module tb_score_seg_driver;

  localparam int unsigned NUM_W = 21;

  logic             clk;
  logic             rst;
  logic [NUM_W-1:0] number;
  logic [3:0]       an;
  logic [6:0]       seg;
  logic             dp;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  score_seg_driver #(
    .CLK_HZ (400),
    .SCAN_HZ(100),
    .NUM_W  (NUM_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .number(number),
    .an    (an),
    .seg   (seg),
    .dp    (dp),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain decimal arithmetic on the score.
  function automatic logic [6:0] seg_of(input int unsigned d);
    case (d)
      0: seg_of = 7'b1000000;
      1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;
      3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;
      5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;
      7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;
      9: seg_of = 7'b0010000;
      default: seg_of = 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg(input int unsigned n, input int idx);
    int unsigned v;
    int unsigned p;
    v = (n > 9999) ? 9999 : n;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && v < p) return 7'h7F;
`endif
    return seg_of((v / p) % 10);
  endfunction

  function automatic logic exp_dp(input int unsigned n, input int idx);
    return !((n > 9999) && (idx == 0));
  endfunction

  task automatic wait_idle(output int to);
    int c;
    c = 0;
    while (busy && c < 200) begin
      @(negedge clk);
      c++;
    end
    to = busy ? 1 : 0;
  endtask

  // Captures what each digit slot shows over one full scan (16 cycles).
  task automatic observe(output logic [27:0] segs, output logic [3:0] dps,
                         output logic [3:0] seen, output int bad);
    int k;
    segs = '1;
    dps  = '1;
    seen = '0;
    bad  = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (an)
        4'hE:    k = 0;
        4'hD:    k = 1;
        4'hB:    k = 2;
        4'h7:    k = 3;
        default: k = -1;
      endcase
      if (k < 0) begin
        bad++;
      end else begin
        segs[7*k +: 7] = seg;
        dps[k]         = dp;
        seen[k]        = 1'b1;
      end
    end
  endtask

  task automatic show(input int unsigned n, output logic [27:0] segs, output logic [3:0] dps,
                      output logic [3:0] seen, output int bad);
    int to;
    number = NUM_W'(n);
    @(negedge clk);
    wait_idle(to);
    observe(segs, dps, seen, bad);
    bad = bad + 100 * to;
  endtask

  task automatic test_reset();
    int idx;
    number = '0;
    rst    = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: an=%h seg=%h dp=%b busy=%b, required F 7F 1 0", an, seg, dp, busy);
    end
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      idx = ((k - 1) / 4) % 4;
      n_tests++;
      if (an !== ~(4'b0001 << idx) || seg !== exp_seg(0, idx) || dp !== 1'b1 ||
          busy !== (k <= 23)) begin
        n_fail++;
        $display("FAIL reset_scan k=%0d: an=%h seg=%b dp=%b busy=%b, required %h %b 1 %b",
                 k, an, seg, dp, busy, ~(4'b0001 << idx), exp_seg(0, idx), (k <= 23));
      end
    end
  endtask

  task automatic test_latency();
    int cnt;
    logic first;
    logic [27:0] segs;
    logic [3:0] dps, seen;
    int bad;
    number = NUM_W'(1234);
    cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) first = busy;
      if (busy) cnt++;
    end
    n_tests++;
    if (first !== 1'b1 || cnt != 23) begin
      n_fail++;
      $display("FAIL latency: first busy=%b busy cycles=%0d, required 1 and 23", first, cnt);
    end
    observe(segs, dps, seen, bad);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (bad != 0 || !seen[i] || segs[7*i +: 7] !== exp_seg(1234, i) || dps[i] !== 1'b1) begin
        n_fail++;
        $display("FAIL latency_digit%0d: seg=%b dp=%b bad=%0d, required seg=%b dp=1",
                 i, segs[7*i +: 7], dps[i], bad, exp_seg(1234, i));
      end
    end
  endtask

  task automatic test_saturation();
    int unsigned vals[3] = '{9999, 10000, 2097151};
    logic [27:0] segs;
    logic [3:0] dps, seen;
    int bad;
    foreach (vals[j]) begin
      show(vals[j], segs, dps, seen, bad);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (bad != 0 || !seen[i] || segs[7*i +: 7] !== exp_seg(vals[j], i) ||
            dps[i] !== exp_dp(vals[j], i)) begin
          n_fail++;
          $display("FAIL sat n=%0d digit%0d: seg=%b dp=%b bad=%0d, required seg=%b dp=%b",
                   vals[j], i, segs[7*i +: 7], dps[i], bad, exp_seg(vals[j], i),
                   exp_dp(vals[j], i));
        end
      end
    end
  endtask

  task automatic test_inflight_change();
    int unsigned vals[2] = '{100, 200};
    logic [27:0] segs;
    logic [3:0] dps, seen;
    int bad, to;
    show(7, segs, dps, seen, bad);
    number = NUM_W'(100);
    repeat (5) @(negedge clk);
    number = NUM_W'(200);
    foreach (vals[j]) begin
      wait_idle(to);
      observe(segs, dps, seen, bad);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (to != 0 || bad != 0 || !seen[i] || segs[7*i +: 7] !== exp_seg(vals[j], i) ||
            dps[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL inflight n=%0d digit%0d: seg=%b dp=%b bad=%0d to=%0d, required seg=%b",
                   vals[j], i, segs[7*i +: 7], dps[i], bad, to, exp_seg(vals[j], i));
        end
      end
      if (j == 0) begin
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL inflight_reconvert: busy=%b, required 1", busy);
        end
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [27:0] segs;
    logic [3:0] dps, seen;
    int bad, to;
    number = NUM_W'(4321);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: an=%h seg=%h dp=%b busy=%b, required F 7F 1 0", an, seg, dp, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_reconvert_start: busy=%b, required 1", busy);
    end
    wait_idle(to);
    observe(segs, dps, seen, bad);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (to != 0 || bad != 0 || !seen[i] || segs[7*i +: 7] !== exp_seg(4321, i)) begin
        n_fail++;
        $display("FAIL reset_reconvert digit%0d: seg=%b bad=%0d to=%0d, required seg=%b",
                 i, segs[7*i +: 7], bad, to, exp_seg(4321, i));
      end
    end
  endtask

  task automatic test_small_numbers();
    int unsigned vals[3] = '{42, 0, 305};
    logic [27:0] segs;
    logic [3:0] dps, seen;
    int bad;
    foreach (vals[j]) begin
      show(vals[j], segs, dps, seen, bad);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (bad != 0 || !seen[i] || segs[7*i +: 7] !== exp_seg(vals[j], i) || dps[i] !== 1'b1) begin
          n_fail++;
          $display("FAIL small n=%0d digit%0d: seg=%b dp=%b bad=%0d, required seg=%b dp=1",
                   vals[j], i, segs[7*i +: 7], dps[i], bad, exp_seg(vals[j], i));
        end
      end
    end
  endtask

  task automatic test_random();
    int unsigned n;
    logic [27:0] segs;
    logic [3:0] dps, seen;
    int bad;
    for (int j = 0; j < 12; j++) begin
      case (j % 3)
        0:       n = $urandom_range(0, 99);
        1:       n = $urandom_range(100, 9999);
        default: n = $urandom_range(10000, 2097151);
      endcase
      show(n, segs, dps, seen, bad);
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (bad != 0 || !seen[i] || segs[7*i +: 7] !== exp_seg(n, i) || dps[i] !== exp_dp(n, i)) begin
          n_fail++;
          $display("FAIL random n=%0d digit%0d: seg=%b dp=%b bad=%0d, required seg=%b dp=%b",
                   n, i, segs[7*i +: 7], dps[i], bad, exp_seg(n, i), exp_dp(n, i));
        end
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    number = '0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_saturation();
    test_inflight_change();
    test_reset_mid_shift();
    test_small_numbers();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
